// File: rtl/ram_refresh_seq_pkg.sv
// rtl/ram_refresh_seq_pkg.sv - shared types and constants for the DRAM refresh sequencer
//
// Purpose: state encoding, default CBR timing and counter widths used by ram_refresh_seq.
// Ports:   none (package).

package ram_refresh_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAS  = 2'd1,
    RAS  = 2'd2,
    PRE  = 2'd3
  } refState_t;

  localparam int unsigned DEF_CAS_SETUP = 1;
  localparam int unsigned DEF_RAS_LOW   = 3;
  localparam int unsigned DEF_PRECHARGE = 2;

  localparam int unsigned MISSED_W = 4;
  localparam int unsigned PHASE_W  = 3;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [PHASE_W-1:0] phaseLoad(input int unsigned cycles);
    return PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ram_refresh_seq.sv
// rtl/ram_refresh_seq.sv - CAS-before-RAS DRAM refresh sequencer, one refresh per timer window
//
// Purpose: consumes the RefReq/RefUrg window from the refresh timer and issues a single
//          CBR refresh per window, opportunistically on an idle bus or, when urgent, by
//          holding off new DRAM accesses through RAMHold.
// Ports:
//   CLK      in   FSB clock, rising edge
//   RES      in   asynchronous active-high reset
//   RefReq   in   refresh window open
//   RefUrg   in   refresh urgent (end of window)
//   BACT     in   FSB bus cycle active
//   RAMCS    in   current bus cycle targets DRAM
//   nRAS     out  DRAM RAS, active low, registered
//   nCAS     out  DRAM CAS, active low, registered
//   RAMHold  out  stall start of new DRAM accesses, registered
//   RefDone  out  refresh completed in the current window
//   RefBusy  out  sequencer not in IDLE
//   Missed   out  saturating count of windows closed without a refresh

module ram_refresh_seq
  import ram_refresh_seq_pkg::*;
#(
  parameter int unsigned CAS_SETUP = DEF_CAS_SETUP,
  parameter int unsigned RAS_LOW   = DEF_RAS_LOW,
  parameter int unsigned PRECHARGE = DEF_PRECHARGE
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                RefReq,
  input  logic                RefUrg,
  input  logic                BACT,
  input  logic                RAMCS,
  output logic                nRAS,
  output logic                nCAS,
  output logic                RAMHold,
  output logic                RefDone,
  output logic                RefBusy,
  output logic [MISSED_W-1:0] Missed
);

  refState_t          state;
  refState_t          stateNext;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phaseNext;
  logic               nRasNext;
  logic               nCasNext;
  logic               refDoneNext;
  logic               refReqQ;
  logic               urgEff;
  logic               startOk;
  logic               missInc;
  logic               holdNext;

  always_comb begin
    // Urgent without an open window is meaningless; ignore it.
    urgEff  = RefUrg && RefReq;
    // Non-urgent needs a fully idle bus; urgent only needs no DRAM cycle in flight.
    startOk = RefReq && !RefDone && !(BACT && RAMCS) && (urgEff || !BACT);
    missInc = refReqQ && !RefReq && !RefDone && (state == IDLE);

    stateNext   = state;
    phaseNext   = phase;
    nRasNext    = nRAS;
    nCasNext    = nCAS;
    refDoneNext = RefDone;

    case (state)
      IDLE: begin
        if (startOk) begin
          stateNext = CAS;
          phaseNext = phaseLoad(CAS_SETUP);
          nCasNext  = 1'b0;
        end else if (!RefReq) begin
          refDoneNext = 1'b0;
        end
      end
      CAS: begin
        if (phase == '0) begin
          stateNext = RAS;
          phaseNext = phaseLoad(RAS_LOW);
          nRasNext  = 1'b0;
        end else begin
          phaseNext = phase - 1'b1;
        end
      end
      RAS: begin
        // The only edge where both strobes move together.
        if (phase == '0) begin
          stateNext = PRE;
          phaseNext = phaseLoad(PRECHARGE);
          nRasNext  = 1'b1;
          nCasNext  = 1'b1;
        end else begin
          phaseNext = phase - 1'b1;
        end
      end
      PRE: begin
        if (phase == '0) begin
          stateNext   = IDLE;
          phaseNext   = '0;
          refDoneNext = 1'b1;
        end else begin
          phaseNext = phase - 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        phaseNext = '0;
        nRasNext  = 1'b1;
        nCasNext  = 1'b1;
      end
    endcase

    holdNext = (stateNext != IDLE) || (urgEff && !refDoneNext);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state   <= IDLE;
      phase   <= '0;
      nRAS    <= 1'b1;
      nCAS    <= 1'b1;
      RAMHold <= 1'b0;
      RefDone <= 1'b0;
      RefBusy <= 1'b0;
      Missed  <= '0;
      refReqQ <= 1'b0;
    end else begin
      state   <= stateNext;
      phase   <= phaseNext;
      nRAS    <= nRasNext;
      nCAS    <= nCasNext;
      RAMHold <= holdNext;
      RefDone <= refDoneNext;
      RefBusy <= (stateNext != IDLE);
      refReqQ <= RefReq;
      if (missInc && (Missed != '1)) begin
        Missed <= Missed + MISSED_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_refresh_seq.sv
// tb/tb_ram_refresh_seq.sv - self-checking bench for ram_refresh_seq
//
// Purpose: directed scenarios followed by randomized refresh windows, every cycle checked
//          against a cycle-offset reference model.
// Ports:   none (top-level bench).

module tb_ram_refresh_seq;

  localparam int CS    = 1;
  localparam int RL    = 3;
  localparam int PR    = 2;
  localparam int TOTAL = CS + RL + PR;

  logic       CLK;
  logic       RES;
  logic       RefReq;
  logic       RefUrg;
  logic       BACT;
  logic       RAMCS;
  logic       nRAS;
  logic       nCAS;
  logic       RAMHold;
  logic       RefDone;
  logic       RefBusy;
  logic [3:0] Missed;

  int checks   = 0;
  int failures = 0;

  // Reference model: mOff is the number of cycles elapsed since the refresh start edge
  // (0 = no refresh running). Strobes follow from that offset by plain arithmetic.
  int   mOff;
  logic mDone;
  int   mMissed;
  logic mPrevReq;
  logic mHold;
  int   mStarts;
  int   dutFalls;
  logic prevNcas;

  ram_refresh_seq #(
    .CAS_SETUP (CS),
    .RAS_LOW   (RL),
    .PRECHARGE (PR)
  ) dut (
    .CLK     (CLK),
    .RES     (RES),
    .RefReq  (RefReq),
    .RefUrg  (RefUrg),
    .BACT    (BACT),
    .RAMCS   (RAMCS),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .RAMHold (RAMHold),
    .RefDone (RefDone),
    .RefBusy (RefBusy),
    .Missed  (Missed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chkBit(input logic got, input logic exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chkInt(input int got, input int exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOff     = 0;
    mDone    = 1'b0;
    mMissed  = 0;
    mPrevReq = 1'b0;
    mHold    = 1'b0;
  endtask

  task automatic modelStep(input logic req, input logic urg, input logic bact, input logic ramcs);
    logic urgE;
    logic idle;
    logic start;
    urgE = urg && req;
    idle = (mOff == 0);
    if (idle && mPrevReq && !req && !mDone && mMissed < 15) mMissed++;
    if (idle) begin
      start = req && !mDone && !(bact && ramcs) && (urgE || !bact);
      if (start) begin
        mOff = 1;
        mStarts++;
      end else if (!req) begin
        mDone = 1'b0;
      end
    end else if (mOff == TOTAL) begin
      mOff  = 0;
      mDone = 1'b1;
    end else begin
      mOff++;
    end
    mHold    = (mOff != 0) || (urgE && !mDone);
    mPrevReq = req;
  endtask

  task automatic checkAll();
    chkBit(nCAS, !(mOff >= 1 && mOff <= CS + RL), "nCAS");
    chkBit(nRAS, !(mOff > CS && mOff <= CS + RL), "nRAS");
    chkBit(RefBusy, mOff != 0, "RefBusy");
    chkBit(RefDone, mDone, "RefDone");
    chkBit(RAMHold, mHold, "RAMHold");
    chkInt(int'(Missed), mMissed, "Missed");
  endtask

  task automatic cycle(input logic req, input logic urg, input logic bact, input logic ramcs);
    RefReq = req;
    RefUrg = urg;
    BACT   = bact;
    RAMCS  = ramcs;
    @(posedge CLK);
    modelStep(req, urg, bact, ramcs);
    #1;
    checkAll();
    if (prevNcas === 1'b1 && nCAS === 1'b0) dutFalls++;
    prevNcas = nCAS;
  endtask

  initial begin
    RES      = 1'b1;
    RefReq   = 1'b0;
    RefUrg   = 1'b0;
    BACT     = 1'b0;
    RAMCS    = 1'b0;
    mStarts  = 0;
    dutFalls = 0;
    prevNcas = 1'b1;
    modelReset();

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    chkBit(nRAS, 1'b1, "rst_nRAS");
    chkBit(nCAS, 1'b1, "rst_nCAS");
    chkBit(RAMHold, 1'b0, "rst_RAMHold");
    chkBit(RefDone, 1'b0, "rst_RefDone");
    chkBit(RefBusy, 1'b0, "rst_RefBusy");
    chkInt(int'(Missed), 0, "rst_Missed");
    RES = 1'b0;

    // Idle bus window: exactly one refresh with nominal timing
    repeat (3) cycle(0, 0, 0, 0);
    dutFalls = 0;
    repeat (15) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    chkInt(dutFalls, 1, "idle_one_refresh");

    // Bus busy on non-DRAM cycles: waits for RefUrg
    dutFalls = 0;
    repeat (10) cycle(1, 0, 1, 0);
    chkInt(dutFalls, 0, "bact_no_refresh");
    repeat (10) cycle(1, 1, 1, 0);
    repeat (2) cycle(0, 0, 1, 0);
    chkInt(dutFalls, 1, "bact_urg_refresh");

    // DRAM cycle in flight across RefUrg rise: hold, then refresh once it drops
    dutFalls = 0;
    repeat (8) cycle(1, 0, 1, 1);
    repeat (12) cycle(1, 1, 1, 1);
    chkInt(dutFalls, 0, "ramcs_no_refresh");
    chkBit(RAMHold, 1'b1, "ramcs_hold");
    repeat (10) cycle(1, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    chkInt(dutFalls, 1, "ramcs_then_refresh");

    // Windows closing under continuous DRAM traffic: Missed counts and saturates
    for (int w = 0; w < 16; w++) begin
      repeat (3) cycle(1, 0, 1, 1);
      repeat (2) cycle(0, 0, 1, 1);
    end
    chkInt(int'(Missed), 15, "missed_saturate");

    // RefReq falls during RAS: refresh completes, not counted as missed
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && nRAS !== 1'b0; i++) cycle(1, 0, 0, 0);
    chkBit(nRAS, 1'b0, "reach_ras");
    repeat (8) cycle(0, 0, 0, 0);
    chkInt(int'(Missed), 15, "fall_in_ras_missed");
    dutFalls = 0;
    repeat (12) cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    chkInt(dutFalls, 1, "next_window_refresh");

    // Asynchronous reset while nRAS is low
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && nRAS !== 1'b0; i++) cycle(1, 0, 0, 0);
    chkBit(nRAS, 1'b0, "reach_ras_rst");
    #2;
    RES    = 1'b1;
    RefReq = 1'b0;
    RefUrg = 1'b0;
    BACT   = 1'b0;
    RAMCS  = 1'b0;
    #1;
    chkBit(nRAS, 1'b1, "async_nRAS");
    chkBit(nCAS, 1'b1, "async_nCAS");
    modelReset();
    @(posedge CLK);
    #1;
    chkBit(RefDone, 1'b0, "rst2_RefDone");
    chkBit(RAMHold, 1'b0, "rst2_RAMHold");
    chkInt(int'(Missed), 0, "rst2_Missed");
    RES      = 1'b0;
    prevNcas = 1'b1;
    repeat (2) cycle(0, 0, 0, 0);

    // Randomized windows
    for (int w = 0; w < 40; w++) begin
      int onLen;
      int urgLen;
      int offLen;
      int busyPct;
      onLen   = int'($urandom_range(4, 24));
      urgLen  = int'($urandom_range(0, 5));
      offLen  = int'($urandom_range(1, 8));
      busyPct = int'($urandom_range(0, 100));
      for (int c = 0; c < onLen; c++) begin
        logic b;
        b = (int'($urandom_range(0, 99)) < busyPct);
        cycle(1, (onLen - c) <= urgLen, b, b && ($urandom_range(0, 1) == 1));
      end
      for (int c = 0; c < offLen; c++) begin
        logic b;
        b = (int'($urandom_range(0, 99)) < busyPct);
        cycle(0, $urandom_range(0, 9) == 0, b, $urandom_range(0, 1) == 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
